// File: rtl/exu_flush_req_swc_if.sv
// Redirect-request bundle between the EXU and the flush-code producer.
// master drives requests, phase and stall feedback; slave returns the flush code and redirect target.
interface exu_flush_req_swc_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 4
);
  logic [CNT_W-1:0] cycle_cnt;
  logic             flush_stall;
  logic             br_vld;
  logic [XLEN-1:0]  br_tgt;
  logic             jmp_vld;
  logic [XLEN-1:0]  jmp_tgt;
  logic             trap_vld;
  logic [XLEN-1:0]  trap_vec;
  logic [1:0]       flush;
  logic [XLEN-1:0]  flush_pc;
  logic             flush_pc_vld;
  logic             req_drop;

  modport master (
    output cycle_cnt, flush_stall, br_vld, br_tgt, jmp_vld, jmp_tgt, trap_vld, trap_vec,
    input  flush, flush_pc, flush_pc_vld, req_drop
  );

  modport slave (
    input  cycle_cnt, flush_stall, br_vld, br_tgt, jmp_vld, jmp_tgt, trap_vld, trap_vec,
    output flush, flush_pc, flush_pc_vld, req_drop
  );
endinterface

// File: rtl/exu_flush_req_swc.sv
// Picks one EXU redirect request (trap > jmp > br), holds its flush code until the sample phase.
// Optional perf counters (flush1_cnt, flush2_cnt, drop_cnt) are built when EXU_FLUSH_PERF_EN is defined.
module exu_flush_req_swc #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 4,
  parameter int SAMPLE_CNT = 4
) (
  input  logic                hclk,
  input  logic                hrstn,
  exu_flush_req_swc_if.slave  bus
`ifdef EXU_FLUSH_PERF_EN
  ,
  output logic [15:0]         flush1_cnt,
  output logic [15:0]         flush2_cnt,
  output logic [15:0]         drop_cnt
`endif
);

  localparam logic [1:0]       FLUSH_DISABLE = 2'd0;
  localparam logic [1:0]       FLUSH_CYCLE_1 = 2'd1;
  localparam logic [1:0]       FLUSH_CYCLE_2 = 2'd2;
  localparam int               WD_MAX        = 2 * SAMPLE_CNT + 2;
  localparam int               WD_W          = $clog2(WD_MAX + 1);
  localparam logic [WD_W-1:0]  WD_LAST       = WD_W'(WD_MAX - 1);
  localparam logic [CNT_W-1:0] SAMPLE        = CNT_W'(SAMPLE_CNT);

  typedef enum logic [1:0] {IDLE, ARMED, SHADOW} state_t;

  state_t            state;
  logic [1:0]        flush_q;
  logic [XLEN-1:0]   flush_pc_q;
  logic              flush_pc_vld_q;
  logic              req_drop_q;
  logic              pend_trap;
  logic              seen_stall;
  logic [WD_W-1:0]   wd_cnt;

  logic              any_req;
  logic              multi_req;
  logic              sample_pt;
  logic              consume;
  logic              take_trap;
  logic              drop_nxt;
  logic [1:0]        sel_code;
  logic [XLEN-1:0]   sel_pc;

  assign any_req   = bus.br_vld | bus.jmp_vld | bus.trap_vld;
  assign multi_req = (bus.br_vld & bus.jmp_vld) | (bus.br_vld & bus.trap_vld) |
                     (bus.jmp_vld & bus.trap_vld);
  assign sample_pt = (bus.cycle_cnt == SAMPLE);
  assign consume   = (state == ARMED) && sample_pt;

  // A trap is refused only when an older trap is still pending and not yet consumed.
  assign take_trap = bus.trap_vld && !((state == ARMED) && !sample_pt && pend_trap);

  always_comb begin
    sel_code = FLUSH_CYCLE_1;
    sel_pc   = bus.br_tgt;
    if (bus.trap_vld) begin
      sel_code = FLUSH_CYCLE_2;
      sel_pc   = bus.trap_vec;
    end else if (bus.jmp_vld) begin
      sel_code = FLUSH_CYCLE_2;
      sel_pc   = bus.jmp_tgt;
    end
  end

  always_comb begin
    drop_nxt = 1'b0;
    unique case (state)
      IDLE:    drop_nxt = multi_req;
      ARMED,
      SHADOW:  drop_nxt = take_trap ? multi_req : any_req;
      default: drop_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state          <= IDLE;
      flush_q        <= FLUSH_DISABLE;
      flush_pc_q     <= '0;
      flush_pc_vld_q <= 1'b0;
      req_drop_q     <= 1'b0;
      pend_trap      <= 1'b0;
      seen_stall     <= 1'b0;
      wd_cnt         <= '0;
    end else begin
      flush_pc_vld_q <= 1'b0;
      req_drop_q     <= drop_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ARMED;
            flush_q    <= sel_code;
            flush_pc_q <= sel_pc;
            pend_trap  <= bus.trap_vld;
          end
        end
        ARMED: begin
          if (sample_pt) begin
            state          <= SHADOW;
            flush_q        <= FLUSH_DISABLE;
            flush_pc_vld_q <= 1'b1;
            seen_stall     <= 1'b0;
            wd_cnt         <= '0;
          end
          if (take_trap) begin
            state      <= ARMED;
            flush_q    <= FLUSH_CYCLE_2;
            flush_pc_q <= bus.trap_vec;
            pend_trap  <= 1'b1;
          end
        end
        SHADOW: begin
          if (take_trap) begin
            state      <= ARMED;
            flush_q    <= FLUSH_CYCLE_2;
            flush_pc_q <= bus.trap_vec;
            pend_trap  <= 1'b1;
          end else if (seen_stall && !bus.flush_stall && !sample_pt) begin
            state <= IDLE;
          end else if (!seen_stall && !bus.flush_stall && (wd_cnt == WD_LAST)) begin
            // Downstream never acknowledged the flush; do not stay in the shadow forever.
            state <= IDLE;
          end else begin
            if (bus.flush_stall) seen_stall <= 1'b1;
            if (!seen_stall)     wd_cnt     <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;
  assign bus.flush_pc_vld = flush_pc_vld_q;
  assign bus.req_drop     = req_drop_q;

`ifdef EXU_FLUSH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      flush1_cnt <= '0;
      flush2_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (consume && (flush_q == FLUSH_CYCLE_1)) flush1_cnt <= sat_inc(flush1_cnt);
      if (consume && (flush_q == FLUSH_CYCLE_2)) flush2_cnt <= sat_inc(flush2_cnt);
      if (drop_nxt)                              drop_cnt   <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule
